// File: rtl/fifo_if_pkg.sv
// rtl/fifo_if_pkg.sv - shared defaults, state encoding and counter widths for the FIFO read side
package fifo_if_pkg;

    localparam int DATA_W_DEF   = 8;
    localparam int READ_LAT_DEF = 1;
    localparam int WORD_CNT_W   = 16;
    localparam int DROP_CNT_W   = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } rd_state_t;

endpackage

// File: rtl/fifo_reader_buf.sv
// rtl/fifo_reader_buf.sv - DEPTH-entry circular buffer with occupancy, push/pop/clear
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   clear             synchronous discard of all entries (wins over push/pop)
//   push, push_data   write push_data at the write pointer
//   pop               retire the head entry
//   occ               current number of stored entries (0..DEPTH)
//   head_data         entry at the read pointer, zero when empty
module fifo_reader_buf
    import fifo_if_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = READ_LAT_DEF + 1,
    parameter int OCC_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [OCC_W-1:0]  occ,
    output logic [DATA_W-1:0] head_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    assign head_data = (occ == '0) ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fifo_reader.sv
// rtl/fifo_reader.sv - read-side master draining a synchronous FIFO onto a valid/ready stream
//
// Optional feature macro: FIFO_READER_CNT_EN (adds WORD_CNT and DROP_CNT outputs).
//
// Ports:
//   CLK, RST_N             clock, asynchronous active-low reset
//   FIFO_EMPTY             FIFO empty flag
//   FIFO_RD_EN             FIFO read strobe, one word per high cycle
//   FIFO_DATA              FIFO read data, valid READ_LAT cycles after FIFO_RD_EN
//   FLUSH                  discard buffered and in-flight words
//   M_VALID/M_READY/M_DATA output stream
//   BUSY                   high while any word is buffered or in flight
//   WORD_CNT               (FIFO_READER_CNT_EN) saturating count of delivered words
//   DROP_CNT               (FIFO_READER_CNT_EN) saturating count of words discarded by FLUSH
module fifo_reader
    import fifo_if_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int READ_LAT = READ_LAT_DEF
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              FIFO_EMPTY,
    output logic              FIFO_RD_EN,
    input  logic [DATA_W-1:0] FIFO_DATA,
    input  logic              FLUSH,
    output logic              M_VALID,
    input  logic              M_READY,
    output logic [DATA_W-1:0] M_DATA,
    output logic              BUSY
`ifdef FIFO_READER_CNT_EN
    ,
    output logic [WORD_CNT_W-1:0] WORD_CNT,
    output logic [DROP_CNT_W-1:0] DROP_CNT
`endif
);

    localparam int D     = READ_LAT + 1;
    localparam int OCC_W = $clog2(D + 1);

    logic [OCC_W-1:0]    occ;
    logic [READ_LAT-1:0] inflight;
    logic [READ_LAT-1:0] inflight_next;
    logic [READ_LAT:0]   inflight_ext;
    logic [3:0]          inflight_pc;
    logic [3:0]          credit_sum;
    logic [3:0]          occ_after;
    logic                pop;
    logic                push;
    rd_state_t           state;
    rd_state_t           state_next;

    assign pop  = M_VALID & M_READY;
    assign push = inflight[READ_LAT-1] & ~FLUSH;

    always_comb begin
        inflight_pc = '0;
        for (int i = 0; i < READ_LAT; i++) begin
            inflight_pc = inflight_pc + 4'(inflight[i]);
        end
    end

    // Every word already buffered or on its way holds a slot; a pop this
    // cycle frees one, so the comparison adds pop on the right instead of
    // subtracting it on the left (keeps the arithmetic unsigned-safe).
    assign credit_sum = 4'(occ) + inflight_pc;
    assign FIFO_RD_EN = RST_N & ~FIFO_EMPTY & ~FLUSH
                      & (credit_sum < (4'(D) + 4'(pop)));

    assign inflight_ext  = {inflight, FIFO_RD_EN};
    assign inflight_next = inflight_ext[READ_LAT-1:0];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            inflight <= '0;
        end else if (FLUSH) begin
            inflight <= '0;
        end else begin
            inflight <= inflight_next;
        end
    end

    fifo_reader_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (D),
        .OCC_W  (OCC_W)
    ) u_buf (
        .clk       (CLK),
        .rst_n     (RST_N),
        .clear     (FLUSH),
        .push      (push),
        .push_data (FIFO_DATA),
        .pop       (pop),
        .occ       (occ),
        .head_data (M_DATA)
    );

    assign M_VALID   = (occ != '0);
    assign occ_after = 4'(occ) + 4'(push) - 4'(pop);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (FIFO_RD_EN) begin
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                if (occ_after == '0 && inflight_next == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (FLUSH) begin
            state_next = IDLE;
        end
    end

    assign BUSY = (state == ACTIVE);

`ifdef FIFO_READER_CNT_EN
    logic [3:0]            dropped;
    logic [DROP_CNT_W:0]   drop_sum;

    // A pop in the flush cycle is delivered, so it is not counted as dropped.
    assign dropped  = 4'(occ) - 4'(pop) + inflight_pc;
    assign drop_sum = {1'b0, DROP_CNT} + (DROP_CNT_W + 1)'(dropped);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            WORD_CNT <= '0;
            DROP_CNT <= '0;
        end else begin
            if (pop && WORD_CNT != '1) begin
                WORD_CNT <= WORD_CNT + 1'b1;
            end
            if (FLUSH) begin
                DROP_CNT <= drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// tb/tb_fifo_reader.sv - scoreboard bench for fifo_reader with a behavioural FIFO model
module tb_fifo_reader;

    localparam int DW = 8;
    localparam int L  = 1;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          FIFO_EMPTY;
    logic          FIFO_RD_EN;
    logic [DW-1:0] FIFO_DATA;
    logic          FLUSH;
    logic          M_VALID;
    logic          M_READY;
    logic [DW-1:0] M_DATA;
    logic          BUSY;
`ifdef FIFO_READER_CNT_EN
    logic [15:0]   WORD_CNT;
    logic [7:0]    DROP_CNT;
`endif

    fifo_reader #(.DATA_W(DW), .READ_LAT(L)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .FIFO_EMPTY (FIFO_EMPTY),
        .FIFO_RD_EN (FIFO_RD_EN),
        .FIFO_DATA  (FIFO_DATA),
        .FLUSH      (FLUSH),
        .M_VALID    (M_VALID),
        .M_READY    (M_READY),
        .M_DATA     (M_DATA),
        .BUSY       (BUSY)
`ifdef FIFO_READER_CNT_EN
        ,
        .WORD_CNT   (WORD_CNT),
        .DROP_CNT   (DROP_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    logic [DW-1:0] src [$];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] pdata [L];
    int            src_rd = 0;
    logic          gap = 1'b0;
    int            n_checks = 0;
    int            n_fail = 0;
    int            delivered = 0;
    int            word_exp = 0;
    int            drop_exp = 0;
    logic          s_valid, s_rd, s_busy, s_fl;
    logic [DW-1:0] s_data;

    assign FIFO_DATA = pdata[L-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic upd_empty();
        FIFO_EMPTY = (src_rd >= src.size()) || gap;
    endtask

    task automatic load(input int n, input logic [DW-1:0] base);
        logic [DW-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = base + DW'(i);
            src.push_back(w);
            exp_q.push_back(w);
        end
        upd_empty();
    endtask

    // Words the FIFO has already handed over but the stream has not delivered are lost.
    function automatic int trim();
        int n = 0;
        while (exp_q.size() > (src.size() - src_rd)) begin
            void'(exp_q.pop_front());
            n++;
        end
        return n;
    endfunction

    task automatic step();
        logic [DW-1:0] e;
        @(negedge CLK);
        s_valid = M_VALID;
        s_rd    = FIFO_RD_EN;
        s_busy  = BUSY;
        s_data  = M_DATA;
        s_fl    = FLUSH;
        if (M_VALID && M_READY) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", {24'h0, M_DATA}, 32'hDEAD);
            end else begin
                e = exp_q.pop_front();
                check("stream_data", {24'h0, M_DATA}, {24'h0, e});
            end
            delivered++;
            if (word_exp < 16'hFFFF) word_exp++;
        end
        @(posedge CLK);
        #1;
        for (int i = L - 1; i > 0; i--) pdata[i] = pdata[i-1];
        if (s_rd) begin
            pdata[0] = src[src_rd];
            src_rd++;
        end else begin
            pdata[0] = '0;
        end
        if (s_fl) begin
            drop_exp = drop_exp + trim();
            if (drop_exp > 255) drop_exp = 255;
        end
        upd_empty();
    endtask

    task automatic drain(input string tag, input int bound);
        int c = 0;
        while (exp_q.size() != 0 && c < bound) begin
            step();
            c++;
        end
        check({tag, "_drained"}, exp_q.size(), 0);
        step();
        check({tag, "_busy_low"}, {31'h0, s_busy}, 0);
    endtask

    initial begin
        int first_rd, first_valid, last_valid, vcount, d0;
        logic [DW-1:0] held;

        for (int i = 0; i < L; i++) pdata[i] = '0;
        RST_N   = 1'b0;
        FLUSH   = 1'b0;
        M_READY = 1'b1;
        upd_empty();

        // Reset state with a non-empty FIFO waiting.
        load(16, 8'h01);
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_valid", {31'h0, s_valid}, 0);
            check("rst_data",  {24'h0, s_data}, 0);
            check("rst_busy",  {31'h0, s_busy}, 0);
            check("rst_rd_en", {31'h0, s_rd}, 0);
        end

        // Streaming 0x01..0x10.
        RST_N = 1'b1;
        first_rd = -1; first_valid = -1; last_valid = -1; vcount = 0;
        for (int c = 0; c < 60 && exp_q.size() != 0; c++) begin
            step();
            if (s_rd && first_rd < 0) first_rd = c;
            if (s_valid) begin
                if (first_valid < 0) first_valid = c;
                last_valid = c;
                vcount++;
            end
        end
        check("stream_latency", first_valid - first_rd, L + 1);
        check("stream_count", vcount, 16);
        check("stream_span", last_valid - first_valid, 15);
        drain("stream", 10);

        // Backpressure mid-stream.
        load(16, 8'hC0);
        for (int i = 0; i < 6; i++) step();
        M_READY = 1'b0;
        step();
        held = s_data;
        check("bp_valid", {31'h0, s_valid}, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("bp_hold", {24'h0, s_data}, {24'h0, held});
            check("bp_rd_stop", {31'h0, s_rd}, 0);
        end
        M_READY = 1'b1;
        drain("bp", 60);

        // Empty flag toggling every 3 cycles.
        d0 = delivered;
        load(8, 8'hA0);
        for (int c = 0; c < 200 && exp_q.size() != 0; c++) begin
            if (c % 3 == 0 && c > 0) begin
                gap = ~gap;
                upd_empty();
            end
            step();
        end
        gap = 1'b0;
        upd_empty();
        check("gap_count", delivered - d0, 8);
        drain("gap", 10);

        // FLUSH with one word buffered and one in flight.
        M_READY = 1'b0;
        load(4, 8'hB0);
        step();
        step();
        FLUSH = 1'b1;
        step();
        check("fl_pre_valid", {31'h0, s_valid}, 1);
        check("fl_pre_rd", {31'h0, s_rd}, 0);
        FLUSH = 1'b0;
        step();
        check("fl_valid_low", {31'h0, s_valid}, 0);
`ifdef FIFO_READER_CNT_EN
        check("fl_drop_cnt", {24'h0, DROP_CNT}, drop_exp);
        check("fl_drop_two", {24'h0, DROP_CNT}, 2);
        check("fl_word_cnt", {16'h0, WORD_CNT}, word_exp);
`endif
        M_READY = 1'b1;
        drain("flush", 20);

        // Reset mid-stream with two words buffered.
        M_READY = 1'b0;
        load(4, 8'hE0);
        for (int i = 0; i < 3; i++) step();
        RST_N = 1'b0;
        #1;
        check("mrst_valid", {31'h0, M_VALID}, 0);
        check("mrst_busy",  {31'h0, BUSY}, 0);
        check("mrst_rd_en", {31'h0, FIFO_RD_EN}, 0);
        void'(trim());
        word_exp = 0;
        drop_exp = 0;
        step();
        RST_N   = 1'b1;
        M_READY = 1'b1;
        drain("mrst", 20);

`ifdef FIFO_READER_CNT_EN
        // Word counter saturation.
        load(65540, 8'h00);
        drain("sat", 70000);
        check("sat_word_cnt", {16'h0, WORD_CNT}, word_exp);
        check("sat_ffff", {16'h0, WORD_CNT}, 32'hFFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
